// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer and its transmit-side mux.
package tdm_demux_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_e;

  // Slot index width; at least one bit so a single-channel link still has a port.
  function automatic int slot_width(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position within a frame: wraps after the last slot, reloads to 1 on a sync beat.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SW   = slot_width(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load0,
  input  logic          inc,
  output logic [SW-1:0] slot,
  output logic          last
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
  // Slot 0 is consumed by the sync beat itself, so the next expected slot is 1.
  localparam logic [SW-1:0] AFTER_SYNC = (N_CH == 1) ? '0 : SW'(1);

  assign last = (slot == LAST_SLOT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (load0) begin
      slot <= AFTER_SYNC;
    end else if (inc) begin
      slot <= last ? '0 : slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: locks to frame sync and steers each beat to its channel register.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int SW = slot_width(N_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

  tdm_state_e      state_q, state_d;
  logic [SW-1:0]   slot;
  logic            slot_last;
  logic            load0, inc, wr_en, err_d;
  logic [SW-1:0]   wr_idx;
  logic [N_CH-1:0] valid_d;

  tdm_slot_counter #(.N_CH(N_CH), .SW(SW)) u_slot (
    .clk   (clk),
    .rst   (rst),
    .load0 (load0),
    .inc   (inc),
    .slot  (slot),
    .last  (slot_last)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    load0   = 1'b0;
    inc     = 1'b0;
    err_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (in_sync) begin
            wr_en   = 1'b1;
            load0   = 1'b1;
            state_d = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (in_sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and restarts it.
            wr_en = 1'b1;
            load0 = 1'b1;
            err_d = (slot != '0);
          end else if (slot == '0) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else begin
            wr_en  = 1'b1;
            wr_idx = slot;
            inc    = 1'b1;
          end
        end
      endcase
    end
    for (int k = 0; k < N_CH; k++) begin
      valid_d[k] = wr_en && (wr_idx == SW'(k));
    end
  end

  // NOTE: the channel bank is a handful of flops, not a RAM, so it is reset along with the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_valid   <= valid_d;
      frame_done <= wr_en && (wr_idx == LAST_SLOT);
      sync_err   <= err_d;
      for (int k = 0; k < N_CH; k++) begin
        if (valid_d[k]) ch_data[k*W +: W] <= in_data;
      end
    end
  end

  assign locked = (state_q == ST_LOCK);

endmodule
